instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Instruction-fetch (IF) stage of the CPU pipeline. Owns the program counter and drives the instruction-memory read port. Presents one fetched instruction and its PC per cycle to the IF/ID pipeline register. Handles multi-cycle memory latency, branch/jump redirects from the execute stage (including a redirect that arrives while a fetch is in flight) and pipeline HOLD, using a one-entry holding buffer so that a returned instruction is never re-fetched.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) presented when no valid instruction exists.

Ports:
- CLK  in  1  pipeline clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- HOLD  in  1  pipeline stall from the hazard unit; IF/ID will not load this cycle.
- BRANCH_TAKEN  in  1  redirect request; has priority over HOLD.
- BRANCH_TARGET  in  32  redirect address; bits [1:0] are ignored and forced to 0.
- IMEM_ADDR  out  32  instruction-memory address; always equals PC.
- IMEM_READ  out  1  read request.
- IMEM_READDATA  in  32  instruction word; valid when IMEM_READ=1 and IMEM_BUSYWAIT=0 in the same cycle.
- IMEM_BUSYWAIT  in  1  memory not ready; address must stay stable while this is high.
- IF_PC  out  32  PC of IF_INSTRUCTION (equals PC).
- IF_INSTRUCTION  out  32  instruction to IF/ID, or NOP_INSTR.
- IF_VALID  out  1  high when IF_INSTRUCTION is a real fetched instruction.

## Operation
Registers:
- PC (32)
- STATE ∈ {FETCH, DISCARD, HELD}
- BUF (32)
- REDIRECT_PC (32)

Reset (RESET=1 at an edge): PC←RESET_PC, STATE←FETCH, BUF←0, REDIRECT_PC←0. While RESET=1, the outputs are forced to IMEM_READ=0, IF_VALID=0, IF_INSTRUCTION=NOP_INSTR. A reset in any state abandons the in-flight access; the memory is reset in the same cycle.

Combinational outputs (RESET=0):
- IMEM_READ = 1 in FETCH or DISCARD; 0 in HELD.
- IF_VALID = !BRANCH_TAKEN && ((FETCH && !IMEM_BUSYWAIT) || HELD).
- IF_INSTRUCTION = IMEM_READDATA in FETCH, BUF in HELD, when IF_VALID=1; otherwise NOP_INSTR.

Transitions (BRANCH_TAKEN > HOLD; all PC arithmetic is modulo 2^32, so PC+4 from 32'hFFFF_FFFC wraps to 0):
- FETCH, BRANCH_TAKEN, BUSYWAIT=1: REDIRECT_PC←target, go to DISCARD, PC unchanged.
- FETCH, BRANCH_TAKEN, BUSYWAIT=0: PC←target, stay in FETCH; the returned word is dropped.
- FETCH, !BRANCH, BUSYWAIT=1: hold PC and state.
- FETCH, !BRANCH, BUSYWAIT=0, !HOLD: PC←PC+4.
- FETCH, !BRANCH, BUSYWAIT=0, HOLD: BUF←IMEM_READDATA, go to HELD.
- DISCARD: keep the stale address with IMEM_READ=1 until the memory completes.
  - BRANCH_TAKEN in this state overwrites REDIRECT_PC.
  - On BUSYWAIT=0: PC←(BRANCH_TAKEN ? target : REDIRECT_PC), go to FETCH.
  - The returned data is never output.
- HELD, BRANCH_TAKEN: PC←target, go to FETCH; BUF is discarded.
- HELD, !HOLD: PC←PC+4, go to FETCH.
- HELD, HOLD: stay in HELD.

## Timing
- Zero-wait memory (BUSYWAIT always 0): one instruction per cycle, IF_VALID=1 every cycle, PC increments by 4 per cycle.
- Fetch latency is 1+N cycles for N busy cycles. IF_PC and IF_INSTRUCTION are valid in the cycle BUSYWAIT falls and are captured by IF/ID at the next edge.
- Redirect with the memory idle: the target appears on IMEM_ADDR in the cycle after BRANCH_TAKEN. The IF output in the BRANCH_TAKEN cycle is NOP_INSTR with IF_VALID=0.
- Redirect while busy: IMEM_ADDR stays stable until BUSYWAIT falls. The target is issued the next cycle, and IF_VALID=0 throughout.
- HOLD through HELD: no new memory reads. On HOLD release, the buffered instruction is captured by IF/ID at that edge, and the fetch of PC+4 starts the following cycle.
- HOLD asserted together with BRANCH_TAKEN: the branch wins and no buffering occurs.

## Test plan
- Reset with RESET_PC=0, then zero-wait memory for 4 cycles: IMEM_ADDR sequence 0,4,8,C; IF_VALID=1; IF_INSTRUCTION matches memory; IMEM_READ=0 during reset.
- BUSYWAIT high for 3 cycles at PC=8: IMEM_ADDR stays 8 for 4 cycles; IF_VALID=0 for 3 cycles, then 1 with the correct word; next address is C.
- BRANCH_TAKEN to 0x100 at PC=0x10 with the memory idle: next IMEM_ADDR=0x100; IF_INSTRUCTION=NOP_INSTR in the branch cycle.
- BRANCH_TAKEN to 0x200 while BUSYWAIT=1 at PC=0x20, busy for 2 more cycles: address held at 0x20; word at 0x20 never emitted; then 0x200 fetched; IF_VALID=0 until the 0x200 data returns.
- HOLD for 3 cycles as data for PC=0x30 returns: IMEM_READ=0 during HOLD; IF_INSTRUCTION=word(0x30) held stable; after release the next address is 0x34 and there is no re-read of 0x30.
- Wrap: PC=32'hFFFF_FFFC with zero-wait memory → next IMEM_ADDR=0.

Source files
------------

// File: rtl/instruction_fetch_unit_if.sv
// Bundles the instruction-memory port, the IF/ID output and the redirect/stall controls.
// The master side is the fetch unit; the slave side is the memory, hazard unit and pipeline.
interface instruction_fetch_unit_if;
  logic        hold;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_addr;
  logic        imem_read;
  logic [31:0] imem_readdata;
  logic        imem_busywait;
  logic [31:0] if_pc;
  logic [31:0] if_instruction;
  logic        if_valid;

  modport master (
    input  hold, branch_taken, branch_target, imem_readdata, imem_busywait,
    output imem_addr, imem_read, if_pc, if_instruction, if_valid
  );

  modport slave (
    output hold, branch_taken, branch_target, imem_readdata, imem_busywait,
    input  imem_addr, imem_read, if_pc, if_instruction, if_valid
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// IF stage: owns the PC, drives the instruction-memory read port and feeds IF/ID.
// A one-entry buffer keeps a returned word across HOLD so it is never re-fetched.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic                      clk,
  input logic                      reset,
  instruction_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {StFetch, StDiscard, StHeld} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic [31:0] target;
  logic [31:0] pc_plus4;

  assign target   = bus.branch_target & ~32'h0000_0003;
  assign pc_plus4 = pc_q + 32'd4;

  assign bus.imem_addr = pc_q;
  assign bus.if_pc     = pc_q;

  always_comb begin
    state_d            = state_q;
    pc_d               = pc_q;
    buf_d              = buf_q;
    redirect_pc_d      = redirect_pc_q;
    bus.imem_read      = 1'b0;
    bus.if_valid       = 1'b0;
    bus.if_instruction = NOP_INSTR;

    unique case (state_q)
      StFetch: begin
        bus.imem_read = 1'b1;
        if (bus.branch_taken) begin
          if (bus.imem_busywait) begin
            redirect_pc_d = target;
            state_d       = StDiscard;
          end else begin
            pc_d = target;
          end
        end else if (!bus.imem_busywait) begin
          bus.if_valid       = 1'b1;
          bus.if_instruction = bus.imem_readdata;
          if (bus.hold) begin
            buf_d   = bus.imem_readdata;
            state_d = StHeld;
          end else begin
            pc_d = pc_plus4;
          end
        end
      end
      StDiscard: begin
        // Stale access must complete at a stable address; its data is dropped.
        bus.imem_read = 1'b1;
        if (!bus.imem_busywait) begin
          pc_d    = bus.branch_taken ? target : redirect_pc_q;
          state_d = StFetch;
        end else if (bus.branch_taken) begin
          redirect_pc_d = target;
        end
      end
      StHeld: begin
        if (bus.branch_taken) begin
          pc_d    = target;
          state_d = StFetch;
        end else begin
          bus.if_valid       = 1'b1;
          bus.if_instruction = buf_q;
          if (!bus.hold) begin
            pc_d    = pc_plus4;
            state_d = StFetch;
          end
        end
      end
      default: state_d = StFetch;
    endcase

    if (reset) begin
      bus.imem_read      = 1'b0;
      bus.if_valid       = 1'b0;
      bus.if_instruction = NOP_INSTR;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StFetch;
      pc_q          <= RESET_PC;
      buf_q         <= 32'h0;
      redirect_pc_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      buf_q         <= buf_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios with literal expectations, then
// randomized stall/redirect/latency traffic checked every cycle against a behavioural model.
module tb_instruction_fetch_unit;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  instruction_fetch_unit_if bus ();

  instruction_fetch_unit #(
    .RESET_PC (RESET_PC),
    .NOP_INSTR(NOP_INSTR)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: a fixed scramble of the address, never equal to the bubble in practice.
  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign bus.imem_readdata = word(bus.imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: where the PC is, whether a redirect is waiting on a stale
  // access, whether a word is parked, and which PC IF/ID must capture next.
  logic [31:0] m_pc, m_rpc, m_buf, m_stream;
  bit          m_pend, m_parked;

  always @(negedge clk) begin
    logic [31:0] tgt;
    logic        e_read, e_valid;
    logic [31:0] e_instr;
    tgt = bus.branch_target & ~32'h3;
    if (reset) begin
      chk("reset_read", {31'b0, bus.imem_read}, 32'd0);
      chk("reset_valid", {31'b0, bus.if_valid}, 32'd0);
      chk("reset_instr", bus.if_instruction, NOP_INSTR);
      m_pc = RESET_PC; m_pend = 0; m_parked = 0; m_rpc = 0; m_buf = 0;
      m_stream = RESET_PC;
    end else begin
      if (m_parked) begin
        e_read  = 1'b0;
        e_valid = !bus.branch_taken;
        e_instr = e_valid ? m_buf : NOP_INSTR;
      end else begin
        e_read  = 1'b1;
        e_valid = !m_pend && !bus.branch_taken && !bus.imem_busywait;
        e_instr = e_valid ? word(m_pc) : NOP_INSTR;
      end
      chk("imem_addr", bus.imem_addr, m_pc);
      chk("if_pc", bus.if_pc, m_pc);
      chk("imem_read", {31'b0, bus.imem_read}, {31'b0, e_read});
      chk("if_valid", {31'b0, bus.if_valid}, {31'b0, e_valid});
      chk("if_instruction", bus.if_instruction, e_instr);
      // Program-order stream seen by IF/ID: sequential except right after a redirect.
      if (bus.if_valid && !bus.hold) begin
        chk("stream_pc", bus.if_pc, m_stream);
        chk("stream_word", bus.if_instruction, word(bus.if_pc));
        m_stream = bus.if_pc + 32'd4;
      end
      if (bus.branch_taken) m_stream = tgt;

      if (m_parked) begin
        if (bus.branch_taken) begin
          m_pc = tgt; m_parked = 0;
        end else if (!bus.hold) begin
          m_pc = m_pc + 32'd4; m_parked = 0;
        end
      end else if (bus.imem_busywait) begin
        if (bus.branch_taken) begin
          m_pend = 1; m_rpc = tgt;
        end
      end else begin
        if (bus.branch_taken) m_pc = tgt;
        else if (m_pend) m_pc = m_rpc;
        else if (bus.hold) begin
          m_parked = 1; m_buf = word(m_pc);
        end else m_pc = m_pc + 32'd4;
        m_pend = 0;
      end
    end
  end

  task automatic step(input logic r, input logic h, input logic b, input logic [31:0] t,
                      input logic bw);
    @(posedge clk);
    #1;
    reset             = r;
    bus.hold          = h;
    bus.branch_taken  = b;
    bus.branch_target = t;
    bus.imem_busywait = bw;
  endtask

  task automatic look();
    @(negedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    bus.hold = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_target = 32'h0;
    bus.imem_busywait = 1'b0;

    for (int i = 0; i < 2; i++) begin
      step(1, 0, 0, 0, 0); look();
      chk("lit_reset_read", {31'b0, bus.imem_read}, 32'd0);
    end

    // Zero-wait fetch, then three busy cycles at 0x8.
    step(0, 0, 0, 0, 0); look();
    chk("lit_addr0", bus.imem_addr, 32'h0);
    chk("lit_instr0", bus.if_instruction, word(32'h0));
    step(0, 0, 0, 0, 0); look();
    chk("lit_addr4", bus.imem_addr, 32'h4);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 1); look();
      chk("lit_busy_addr", bus.imem_addr, 32'h8);
      chk("lit_busy_valid", {31'b0, bus.if_valid}, 32'd0);
    end
    step(0, 0, 0, 0, 0); look();
    chk("lit_done_addr", bus.imem_addr, 32'h8);
    chk("lit_done_valid", {31'b0, bus.if_valid}, 32'd1);
    chk("lit_done_instr", bus.if_instruction, word(32'h8));
    step(0, 0, 0, 0, 0); look();
    chk("lit_addrC", bus.imem_addr, 32'hC);

    // Idle-memory redirect at 0x10.
    step(0, 0, 1, 32'h100, 0); look();
    chk("lit_br_addr", bus.imem_addr, 32'h10);
    chk("lit_br_instr", bus.if_instruction, NOP_INSTR);
    step(0, 0, 0, 0, 0); look();
    chk("lit_br_target", bus.imem_addr, 32'h100);

    // Redirect while busy at 0x20.
    step(0, 0, 1, 32'h20, 0); look();
    step(0, 0, 1, 32'h200, 1); look();
    chk("lit_bb_addr", bus.imem_addr, 32'h20);
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 0, 0, 1); look();
      chk("lit_bb_hold_addr", bus.imem_addr, 32'h20);
    end
    step(0, 0, 0, 0, 0); look();
    chk("lit_bb_drop", {31'b0, bus.if_valid}, 32'd0);
    step(0, 0, 0, 0, 0); look();
    chk("lit_bb_target", bus.imem_addr, 32'h200);
    chk("lit_bb_instr", bus.if_instruction, word(32'h200));

    // HOLD as the word for 0x30 returns.
    step(0, 0, 1, 32'h30, 0); look();
    step(0, 1, 0, 0, 0); look();
    chk("lit_hold_instr", bus.if_instruction, word(32'h30));
    for (int i = 0; i < 2; i++) begin
      step(0, 1, 0, 0, 0); look();
      chk("lit_held_read", {31'b0, bus.imem_read}, 32'd0);
      chk("lit_held_instr", bus.if_instruction, word(32'h30));
    end
    step(0, 0, 0, 0, 0); look();
    chk("lit_release_read", {31'b0, bus.imem_read}, 32'd0);
    step(0, 0, 0, 0, 0); look();
    chk("lit_after_hold", bus.imem_addr, 32'h34);

    // HOLD together with a branch: branch wins, nothing parked.
    step(0, 1, 1, 32'h40, 0); look();
    step(0, 0, 0, 0, 0); look();
    chk("lit_hb_addr", bus.imem_addr, 32'h40);
    chk("lit_hb_read", {31'b0, bus.imem_read}, 32'd1);

    // Target low bits ignored, then PC wraps.
    step(0, 0, 1, 32'hFFFF_FFFF, 0); look();
    step(0, 0, 0, 0, 0); look();
    chk("lit_top_addr", bus.imem_addr, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 0); look();
    chk("lit_wrap_addr", bus.imem_addr, 32'h0);

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] t;
      logic        r;
      t = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
      r = ($urandom_range(0, 99) == 0);
      step(r, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, t,
           !r && ($urandom_range(0, 9) < 3));
    end
    step(0, 0, 0, 0, 0);
    look();
    look();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
